// File: rtl/contador_mod_updown_pkg.sv
// Shared definitions for the modulo-M counter family: direction encoding
// and the elaboration-time parameter legality test.
package contador_mod_updown_pkg;

   typedef enum logic {
      SOBE  = 1'b0,
      DESCE = 1'b1
   } direcao_t;

   // True when width n and modulus m describe a realisable counter:
   // n >= 2 and 2 <= m <= 2**n.
   function automatic bit param_legal(input int n, input int m);
      if (n < 2) return 1'b0;
      if (m < 2) return 1'b0;
      // Any positive int modulus fits once 2**n exceeds the int range.
      if (n >= 31) return 1'b1;
      return (m <= (1 << n));
   endfunction

endpackage

// File: rtl/contador_mod_updown_comparador.sv
// Unsigned N-bit magnitude comparator: exactly one of igual/menor/maior is high.
module comparador_n #(
   parameter int N = 4
) (
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic         igual,
   output logic         menor,
   output logic         maior
);

   // Purely combinational relation of A against B.
   always_comb begin
      igual = (A == B);
      menor = (A <  B);
      maior = (A >  B);
   end

endmodule

// File: rtl/contador_mod_updown.sv
// Modulo-M up/down counter with synchronous clear and load, 74163-style
// enables and ripple carry, registered wrap / load-clamp pulses and a
// built-in magnitude comparator of the count against operand B.
module contador_mod_updown
   import contador_mod_updown_pkg::*;
#(
   parameter int N = 4,
   parameter int M = 16
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         zera_s,
   input  logic         carrega,
   input  logic [N-1:0] D,
   input  logic         enp,
   input  logic         ent,
   input  logic         desce,
   input  logic [N-1:0] B,
   output logic [N-1:0] Q,
   output logic         rco,
   output logic         fim,
   output logic         erro_carga,
   output logic         igual,
   output logic         menor,
   output logic         maior
);

   if (!param_legal(N, M)) begin : g_param_illegal
      $error("contador_mod_updown: illegal parameters N=%0d M=%0d", N, M);
   end

   localparam logic [N-1:0] MAX = (N)'(M - 1);
   localparam logic [N-1:0] UM  = (N)'(1);

   direcao_t dir;
   logic     terminal;

   // Terminal count depends on direction: top of range going up, zero going down.
   always_comb begin
      dir      = direcao_t'(desce);
      terminal = (dir == SOBE) ? (Q == MAX) : (Q == '0);
      rco      = ent & terminal;
   end

   // Counter register and one-cycle status pulses; priority clear > load > count > hold.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         Q          <= '0;
         fim        <= 1'b0;
         erro_carga <= 1'b0;
      end else begin
         fim        <= 1'b0;
         erro_carga <= 1'b0;
         if (zera_s) begin
            Q <= '0;
         end else if (carrega) begin
            // Out-of-range loads saturate to the top of the count range.
            if (D > MAX) begin
               Q          <= MAX;
               erro_carga <= 1'b1;
            end else begin
               Q <= D;
            end
         end else if (enp && ent) begin
            // Explicit wrap at the range ends instead of relying on N-bit overflow.
            if (terminal) begin
               Q   <= (dir == SOBE) ? '0 : MAX;
               fim <= 1'b1;
            end else begin
               Q <= (dir == SOBE) ? (Q + UM) : (Q - UM);
            end
         end
      end
   end

   comparador_n #(.N(N)) u_comparador (
      .A     (Q),
      .B     (B),
      .igual (igual),
      .menor (menor),
      .maior (maior)
   );

endmodule

// File: tb/tb_contador_mod_updown.sv
// Directed bench for contador_mod_updown: N=4/M=10 main instance plus an
// N=3/M=8 instance for the natural-overflow wrap case.
module tb_contador_mod_updown;

   localparam int MOD  = 10;
   localparam int MOD2 = 8;

   typedef struct {
      int unsigned q;
      logic        f;
      logic        e;
   } exp_t;

   exp_t sb[$];

   int checks = 0;
   int errors = 0;

   logic clock = 1'b0;
   logic reset;

   // Main instance (N=4, M=10)
   logic       zera_s, carrega, enp, ent, desce;
   logic [3:0] D, B, Q;
   logic       rco, fim, erro_carga, igual, menor, maior;

   // Second instance (N=3, M=8)
   logic       zera_s2, carrega2, enp2, ent2, desce2;
   logic [2:0] D2, B2, Q2;
   logic       rco2, fim2, erro_carga2, igual2, menor2, maior2;

   int unsigned mq  = 0;
   int unsigned mq2 = 0;

   always #5 clock = ~clock;

   contador_mod_updown #(.N(4), .M(MOD)) dut (
      .clock(clock), .reset(reset), .zera_s(zera_s), .carrega(carrega), .D(D),
      .enp(enp), .ent(ent), .desce(desce), .B(B), .Q(Q), .rco(rco), .fim(fim),
      .erro_carga(erro_carga), .igual(igual), .menor(menor), .maior(maior)
   );

   contador_mod_updown #(.N(3), .M(MOD2)) dut2 (
      .clock(clock), .reset(reset), .zera_s(zera_s2), .carrega(carrega2), .D(D2),
      .enp(enp2), .ent(ent2), .desce(desce2), .B(B2), .Q(Q2), .rco(rco2), .fim(fim2),
      .erro_carga(erro_carga2), .igual(igual2), .menor(menor2), .maior(maior2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock edge on the main instance: drive, check combinational outputs
   // against the model's current count, queue the predicted state, compare after the edge.
   task automatic step(input string tag, input logic z, input logic c, input logic [3:0] d,
                       input logic p, input logic t, input logic dn, input logic [3:0] b);
      exp_t x;
      zera_s = z; carrega = c; D = d; enp = p; ent = t; desce = dn; B = b;
      #1;
      chk({tag, ".rco"},   32'(rco),   32'(t && (dn ? (mq == 0) : (mq == MOD - 1))));
      chk({tag, ".igual"}, 32'(igual), 32'(mq == b));
      chk({tag, ".menor"}, 32'(menor), 32'(mq <  b));
      chk({tag, ".maior"}, 32'(maior), 32'(mq >  b));
      x.q = mq; x.f = 1'b0; x.e = 1'b0;
      if (z) begin
         x.q = 0;
      end else if (c) begin
         if (d > MOD - 1) begin x.q = MOD - 1; x.e = 1'b1; end
         else x.q = d;
      end else if (p && t) begin
         if (!dn) begin
            if (mq == MOD - 1) begin x.q = 0; x.f = 1'b1; end
            else x.q = mq + 1;
         end else begin
            if (mq == 0) begin x.q = MOD - 1; x.f = 1'b1; end
            else x.q = mq - 1;
         end
      end
      sb.push_back(x);
      mq = x.q;
      @(posedge clock);
      #1;
      x = sb.pop_front();
      chk({tag, ".Q"},          32'(Q),          x.q);
      chk({tag, ".fim"},        32'(fim),        32'(x.f));
      chk({tag, ".erro_carga"}, 32'(erro_carga), 32'(x.e));
   endtask

   // One counting edge on the N=3/M=8 instance.
   task automatic step2(input string tag, input logic dn);
      exp_t x;
      enp2 = 1'b1; ent2 = 1'b1; desce2 = dn;
      #1;
      chk({tag, ".rco"}, 32'(rco2), 32'(dn ? (mq2 == 0) : (mq2 == MOD2 - 1)));
      x.e = 1'b0;
      if (!dn) begin
         x.f = (mq2 == MOD2 - 1);
         x.q = x.f ? 0 : mq2 + 1;
      end else begin
         x.f = (mq2 == 0);
         x.q = x.f ? MOD2 - 1 : mq2 - 1;
      end
      sb.push_back(x);
      mq2 = x.q;
      @(posedge clock);
      #1;
      x = sb.pop_front();
      chk({tag, ".Q"},   32'(Q2),   x.q);
      chk({tag, ".fim"}, 32'(fim2), 32'(x.f));
   endtask

   initial begin
      reset = 1'b1;
      zera_s = 1'b0; carrega = 1'b0; D = '0; enp = 1'b0; ent = 1'b0; desce = 1'b0; B = '0;
      zera_s2 = 1'b0; carrega2 = 1'b0; D2 = '0; enp2 = 1'b0; ent2 = 1'b0; desce2 = 1'b0; B2 = 3'd3;
      #12;
      chk("rst.Q",          32'(Q),          0);
      chk("rst.fim",        32'(fim),        0);
      chk("rst.erro_carga", 32'(erro_carga), 0);
      chk("rst.igual",      32'(igual),      1);
      chk("rst.menor",      32'(menor),      0);
      chk("rst.Q2",         32'(Q2),         0);
      reset = 1'b0;

      // Count to 7, then reset between edges
      for (int i = 0; i < 7; i++) step("t1_up", 0, 0, 4'd0, 1, 1, 0, 4'd0);
      #2 reset = 1'b1;
      #1;
      chk("t1_async.Q",     32'(Q),     0);
      chk("t1_async.fim",   32'(fim),   0);
      chk("t1_async.igual", 32'(igual), 1);
      #1 reset = 1'b0;
      mq = 0;

      // Up count through the 9->0 wrap
      for (int i = 0; i < 12; i++) step("t2_up", 0, 0, 4'd0, 1, 1, 0, 4'd0);

      // Down count from 1 through the 0->9 wrap
      step("t3_dir", 0, 0, 4'd0, 1, 1, 1, 4'd0);
      for (int i = 0; i < 3; i++) step("t3_dn", 0, 0, 4'd0, 1, 1, 1, 4'd0);

      // Loads: clamped, pulse drops on hold, legal, boundary values
      step("t4_ld12",  0, 1, 4'd12, 0, 0, 0, 4'd0);
      step("t4_hold",  0, 0, 4'd0,  0, 0, 0, 4'd0);
      step("t4_ld5",   0, 1, 4'd5,  0, 0, 0, 4'd0);
      step("t4_ld9",   0, 1, 4'd9,  0, 0, 0, 4'd0);
      step("t4_ld10",  0, 1, 4'd10, 0, 0, 0, 4'd0);
      step("t4_ld15",  0, 1, 4'd15, 1, 1, 0, 4'd0);

      // Clear beats load and count; partial enables hold
      step("t5_ld6",   0, 1, 4'd6,  0, 0, 0, 4'd0);
      step("t5_clr",   1, 1, 4'd3,  1, 1, 0, 4'd0);
      step("t5_ld9",   0, 1, 4'd9,  0, 0, 0, 4'd0);
      step("t5_enp",   0, 0, 4'd0,  1, 0, 0, 4'd0);
      step("t5_ent",   0, 0, 4'd0,  0, 1, 0, 4'd0);
      step("t5_dnrco", 0, 0, 4'd0,  0, 1, 1, 4'd0);

      // Comparator sweep against B = 4
      step("t6_clr",   1, 0, 4'd0,  0, 0, 0, 4'd4);
      for (int i = 0; i < 10; i++) step("t6_cmp", 0, 0, 4'd0, 1, 1, 0, 4'd4);

      // N=3, M=8: natural overflow wrap both ways
      for (int i = 0; i < 10; i++) step2("t6b_up", 1'b0);
      for (int i = 0; i < 3; i++)  step2("t6b_dn", 1'b1);
      enp2 = 1'b0; ent2 = 1'b0;
      #1;
      chk("t6b.igual", 32'(igual2), 32'(mq2 == 3));
      chk("t6b.maior", 32'(maior2), 32'(mq2 > 3));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
